// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared select encodings and pipeline stage-record layout
package riscv_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;
    localparam logic [1:0] SEL_IMM   = 2'b11;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memread;
        logic [REG_AW-1:0] rd;
    } stage_rec_t;

    localparam stage_rec_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/fwd_sel_ctrl_if.sv
// rtl/fwd_sel_ctrl_if.sv - decode-side bus of the operand-select controller (FWD_IMM_SEL_EN adds id_alusrc)
interface fwd_sel_ctrl_if
    import riscv_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
`ifdef FWD_IMM_SEL_EN
    logic              id_alusrc;
`endif
    logic              flush;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
`ifdef FWD_IMM_SEL_EN
        output id_alusrc,
`endif
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output id_rd, id_regwrite, id_memread, flush,
        input  fwd_a_sel, fwd_b_sel, stall, stall_cnt
    );

    modport slave (
`ifdef FWD_IMM_SEL_EN
        input  id_alusrc,
`endif
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  id_rd, id_regwrite, id_memread, flush,
        output fwd_a_sel, fwd_b_sel, stall, stall_cnt
    );

endinterface

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - per-source priority comparator against the EX and MEM stage records
module fwd_match
    import riscv_pkg::*;
(
    input  logic              use_rs,
    input  logic [REG_AW-1:0] rs,
    input  stage_rec_t        ex_rec,
    input  logic              mem_valid,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    output logic [1:0]        sel,
    output logic              load_hit
);
    logic ex_hit;
    logic mem_hit;

    // x0 is hard-wired zero, so a match on it must never redirect the operand.
    assign ex_hit  = use_rs & ex_rec.valid & (ex_rec.rd != '0) & (ex_rec.rd == rs);
    assign mem_hit = use_rs & mem_valid & mem_regwrite & (mem_rd != '0) & (mem_rd == rs);

    always_comb begin
        sel = SEL_RF;
        if (ex_hit && ex_rec.regwrite) begin
            sel = SEL_EXMEM;
        end else if (mem_hit) begin
            sel = SEL_MEMWB;
        end
    end

    assign load_hit = ex_hit & ex_rec.memread;

endmodule

// File: rtl/fwd_sel_ctrl.sv
// rtl/fwd_sel_ctrl.sv - EX operand-select controller with load-use stall; FWD_IMM_SEL_EN enables immediate select on operand B
module fwd_sel_ctrl
    import riscv_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input logic          clk,
    input logic          reset,
    fwd_sel_ctrl_if.slave bus
);
    stage_rec_t       ex_q, ex_d;
    stage_rec_t       mem_q, mem_d;
    logic [1:0]       a_sel_q, a_sel_d;
    logic [1:0]       b_sel_q, b_sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       use_b;
    logic [1:0] sel_a, sel_b;
    logic       hit_a, hit_b;
    logic       stall_c;
    logic       advance;

`ifdef FWD_IMM_SEL_EN
    assign use_b = bus.id_use_rs2 & ~bus.id_alusrc;
`else
    assign use_b = bus.id_use_rs2;
`endif

    fwd_match u_match_a (
        .use_rs       (bus.id_use_rs1),
        .rs           (bus.id_rs1),
        .ex_rec       (ex_q),
        .mem_valid    (mem_q.valid),
        .mem_regwrite (mem_q.regwrite),
        .mem_rd       (mem_q.rd),
        .sel          (sel_a),
        .load_hit     (hit_a)
    );

    fwd_match u_match_b (
        .use_rs       (use_b),
        .rs           (bus.id_rs2),
        .ex_rec       (ex_q),
        .mem_valid    (mem_q.valid),
        .mem_regwrite (mem_q.regwrite),
        .mem_rd       (mem_q.rd),
        .sel          (sel_b),
        .load_hit     (hit_b)
    );

    // A taken branch kills the decoded instruction, so it cannot also stall.
    assign stall_c = bus.id_valid & ~bus.flush & (hit_a | hit_b);
    assign advance = bus.id_valid & ~bus.flush & ~stall_c;

    always_comb begin
        ex_d    = STAGE_BUBBLE;
        a_sel_d = SEL_RF;
        b_sel_d = SEL_RF;
        if (advance) begin
            ex_d.valid    = 1'b1;
            ex_d.regwrite = bus.id_regwrite;
            ex_d.memread  = bus.id_memread;
            ex_d.rd       = bus.id_rd;
            a_sel_d       = sel_a;
            b_sel_d       = sel_b;
`ifdef FWD_IMM_SEL_EN
            if (bus.id_alusrc) begin
                b_sel_d = SEL_IMM;
            end
`endif
        end
        // Instructions leaving MEM need no tracking: the register file covers WB.
        mem_d = ex_q;
        cnt_d = cnt_q;
        if (stall_c && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q    <= STAGE_BUBBLE;
            mem_q   <= STAGE_BUBBLE;
            a_sel_q <= SEL_RF;
            b_sel_q <= SEL_RF;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            a_sel_q <= a_sel_d;
            b_sel_q <= b_sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.fwd_a_sel = a_sel_q;
    assign bus.fwd_b_sel = b_sel_q;
    assign bus.stall     = stall_c;
    assign bus.stall_cnt = cnt_q;

endmodule
